// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle control unit: FSM state codes,
// instruction class codes, condition codes and the compare-opcode range.
package ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_LS  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_UND = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // TST/TEQ/CMP/CMN only set flags and never write a register
    localparam logic [3:0] CMP_OP_LO = 4'b1000;
    localparam logic [3:0] CMP_OP_HI = 4'b1011;

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// Combinational ARM condition-code evaluation against the {N,Z,C,V} register.
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n_s, z_s, c_s, v_s;
    assign {n_s, z_s, c_s, v_s} = flags;

    // Condition decode
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_s;
            COND_NE: pass = ~z_s;
            COND_CS: pass = c_s;
            COND_CC: pass = ~c_s;
            COND_MI: pass = n_s;
            COND_PL: pass = ~n_s;
            COND_VS: pass = v_s;
            COND_VC: pass = ~v_s;
            COND_HI: pass = c_s & ~z_s;
            COND_LS: pass = ~c_s | z_s;
            COND_GE: pass = (n_s == v_s);
            COND_LT: pass = (n_s != v_s);
            COND_GT: pass = ~z_s & (n_s == v_s);
            COND_LE: pass = z_s | (n_s != v_s);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with NZCV status register.
// Define CTRL_MEM_HANDSHAKE_EN to make MEM wait for mem_ack; otherwise MEM is one cycle.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    input  logic        alu_c,
    input  logic        mem_ack,
    output logic        RegDest,
    output logic        RegWr,
    output logic        ALUop,
    output logic        ALUSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        PCSrc,
    output logic        PCWr,
    output logic        IRWr,
    output logic [3:0]  flags,
    output logic        undef,
    output logic [2:0]  state
);

    logic [2:0]  state_r, state_nxt_s;
    logic [11:0] ir_r;
    logic [3:0]  flags_r;
    logic        cond_pass_s, mem_done_s, is_cmp_s, flags_we_s;
    logic        regwr_s, aluop_s, alusrc_s, memrd_s, memwr_s, memtoreg_s;
    logic        pcsrc_s, pcwr_s, irwr_s, undef_s;
    logic        unused_s;

    // Only cond/class/I/opcode/S-L are kept from the fetched word
    wire  [3:0] cond_s = ir_r[11:8];
    wire  [1:0] cls_s  = ir_r[7:6];
    wire        imm_s  = ir_r[5];
    wire  [3:0] opc_s  = ir_r[4:1];
    wire        sl_s   = ir_r[0];

    assign unused_s = ^{inst[19:0], mem_ack};

`ifdef CTRL_MEM_HANDSHAKE_EN
    assign mem_done_s = mem_ack;
`else
    assign mem_done_s = 1'b1;
`endif

    assign is_cmp_s   = (opc_s >= CMP_OP_LO) && (opc_s <= CMP_OP_HI);
    assign flags_we_s = (state_r == ST_EXEC) && (cls_s == CLS_DP) && sl_s;

    cond_check u_cond (
        .cond  (cond_s),
        .flags (flags_r),
        .pass  (cond_pass_s)
    );

    // State, instruction and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FETCH;
            ir_r    <= 12'd0;
            flags_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_FETCH) begin
                ir_r <= inst[31:20];
            end
            if (flags_we_s) begin
                flags_r <= {alu_n, alu_z, alu_c, alu_v};
            end
        end
    end

    // Next-state and control strobe decode
    always_comb begin
        state_nxt_s = ST_FETCH;
        regwr_s     = 1'b0;
        aluop_s     = 1'b0;
        alusrc_s    = 1'b0;
        memrd_s     = 1'b0;
        memwr_s     = 1'b0;
        memtoreg_s  = 1'b0;
        pcsrc_s     = 1'b0;
        pcwr_s      = 1'b0;
        irwr_s      = 1'b0;
        undef_s     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                irwr_s      = 1'b1;
                state_nxt_s = ST_DECODE;
            end
            ST_DECODE: begin
                if (!cond_pass_s) begin
                    pcwr_s      = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else if (cls_s == CLS_UND) begin
                    undef_s     = 1'b1;
                    pcwr_s      = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_s)
                    CLS_DP: begin
                        aluop_s  = 1'b1;
                        alusrc_s = imm_s;
                        regwr_s  = ~is_cmp_s;
                        pcwr_s   = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end
                    CLS_LS: begin
                        alusrc_s    = 1'b1;
                        state_nxt_s = ST_MEM;
                    end
                    CLS_BR: begin
                        pcsrc_s     = 1'b1;
                        pcwr_s      = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end
                    default: state_nxt_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                alusrc_s = 1'b1;
                memrd_s  = sl_s;
                memwr_s  = ~sl_s;
                pcwr_s   = ~sl_s & mem_done_s;
                if (!mem_done_s) begin
                    state_nxt_s = ST_MEM;
                end else if (sl_s) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_WB: begin
                regwr_s     = 1'b1;
                memtoreg_s  = 1'b1;
                pcwr_s      = 1'b1;
                state_nxt_s = ST_FETCH;
            end
            default: state_nxt_s = ST_FETCH;
        endcase
    end

    // Strobes are gated by reset so an aborted memory cycle drops at once
    assign RegDest  = 1'b0;
    assign RegWr    = regwr_s    & reset;
    assign ALUop    = aluop_s    & reset;
    assign ALUSrc   = alusrc_s   & reset;
    assign MemRead  = memrd_s    & reset;
    assign MemWrite = memwr_s    & reset;
    assign MemtoReg = memtoreg_s & reset;
    assign PCSrc    = pcsrc_s    & reset;
    assign PCWr     = pcwr_s     & reset;
    assign IRWr     = irwr_s     & reset;
    assign undef    = undef_s    & reset;
    assign flags    = flags_r;
    assign state    = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl, plus hand sequences for
// MEM wait states and reset during MEM. Honours CTRL_MEM_HANDSHAKE_EN.
module tb_multicycle_ctrl;

    logic        clk, reset;
    logic [31:0] inst;
    logic        alu_z, alu_n, alu_v, alu_c, mem_ack;
    logic        RegDest, RegWr, ALUop, ALUSrc, MemRead, MemWrite, MemtoReg;
    logic        PCSrc, PCWr, IRWr, undef;
    logic [3:0]  flags;
    logic [2:0]  state;
    logic [10:0] ctrl_v;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .inst(inst),
        .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
        .mem_ack(mem_ack),
        .RegDest(RegDest), .RegWr(RegWr), .ALUop(ALUop), .ALUSrc(ALUSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .PCSrc(PCSrc), .PCWr(PCWr), .IRWr(IRWr),
        .flags(flags), .undef(undef), .state(state)
    );

    // bit order: RegDest RegWr ALUop ALUSrc MemRead MemWrite MemtoReg PCSrc PCWr IRWr undef
    assign ctrl_v = {RegDest, RegWr, ALUop, ALUSrc, MemRead, MemWrite,
                     MemtoReg, PCSrc, PCWr, IRWr, undef};

    localparam logic [10:0] C_NONE = 11'h000;
    localparam logic [10:0] C_IRW  = 11'h002;
    localparam logic [10:0] C_PCW  = 11'h004;
    localparam logic [10:0] C_UND  = 11'h005;
    localparam logic [10:0] C_BR   = 11'h00C;
    localparam logic [10:0] C_DPI  = 11'h384;
    localparam logic [10:0] C_DPR  = 11'h304;
    localparam logic [10:0] C_CMPI = 11'h184;
    localparam logic [10:0] C_LSE  = 11'h080;
    localparam logic [10:0] C_STA  = 11'h0A4;
    localparam logic [10:0] C_LDM  = 11'h0C0;
    localparam logic [10:0] C_WB   = 11'h214;

    localparam logic [31:0] I_BEQ  = 32'h0A000004;
    localparam logic [31:0] I_ADDS = 32'hE2910001;
    localparam logic [31:0] I_CMP  = 32'hE3510000;
    localparam logic [31:0] I_UND  = 32'hEC000000;
    localparam logic [31:0] I_STR  = 32'hE5810000;
    localparam logic [31:0] I_LDR  = 32'hE5910000;
    localparam logic [31:0] I_ADD  = 32'hE0800000;
    localparam logic [31:0] I_BLT  = 32'hBA000000;

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  aluf;
        logic        ack;
        logic [2:0]  st;
        logic [10:0] ctrl;
        logic [3:0]  fl;
    } row_t;

    row_t rows[64];
    int   nrows = 0;
    int   total = 0;
    int   bad   = 0;
    int   ncyc, nread, mcnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [31:0] i, input logic [3:0] a, input logic k,
                       input logic [2:0] s, input logic [10:0] c, input logic [3:0] f);
        rows[nrows].inst = i;
        rows[nrows].aluf = a;
        rows[nrows].ack  = k;
        rows[nrows].st   = s;
        rows[nrows].ctrl = c;
        rows[nrows].fl   = f;
        nrows++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; inst = 32'd0; mem_ack = 1'b0;
        {alu_n, alu_z, alu_c, alu_v} = 4'b0000;

        // BEQ with Z=0 fails in DECODE
        add(I_BEQ,  4'h0, 1'b0, 3'd0, C_IRW,  4'h0);
        add(I_BEQ,  4'h0, 1'b0, 3'd1, C_PCW,  4'h0);
        // ADDS immediate, ALU reports Z; mem_ack high outside MEM is ignored
        add(I_ADDS, 4'h0, 1'b0, 3'd0, C_IRW,  4'h0);
        add(I_ADDS, 4'h0, 1'b0, 3'd1, C_NONE, 4'h0);
        add(I_ADDS, 4'h4, 1'b1, 3'd2, C_DPI,  4'h0);
        // BEQ now passes on the new Z flag
        add(I_BEQ,  4'h0, 1'b0, 3'd0, C_IRW,  4'h4);
        add(I_BEQ,  4'h0, 1'b0, 3'd1, C_NONE, 4'h4);
        add(I_BEQ,  4'h0, 1'b0, 3'd2, C_BR,   4'h4);
        // CMP: no RegWr, flags become N,C
        add(I_CMP,  4'h0, 1'b0, 3'd0, C_IRW,  4'h4);
        add(I_CMP,  4'h0, 1'b0, 3'd1, C_NONE, 4'h4);
        add(I_CMP,  4'hA, 1'b0, 3'd2, C_CMPI, 4'h4);
        // undefined class
        add(I_UND,  4'h0, 1'b0, 3'd0, C_IRW,  4'hA);
        add(I_UND,  4'h0, 1'b0, 3'd1, C_UND,  4'hA);
        // STR with immediate ack
        add(I_STR,  4'h0, 1'b0, 3'd0, C_IRW,  4'hA);
        add(I_STR,  4'h0, 1'b0, 3'd1, C_NONE, 4'hA);
        add(I_STR,  4'h0, 1'b0, 3'd2, C_LSE,  4'hA);
        add(I_STR,  4'h0, 1'b1, 3'd3, C_STA,  4'hA);
        // LDR with immediate ack
        add(I_LDR,  4'h0, 1'b0, 3'd0, C_IRW,  4'hA);
        add(I_LDR,  4'h0, 1'b0, 3'd1, C_NONE, 4'hA);
        add(I_LDR,  4'h0, 1'b0, 3'd2, C_LSE,  4'hA);
        add(I_LDR,  4'h0, 1'b1, 3'd3, C_LDM,  4'hA);
        add(I_LDR,  4'h0, 1'b0, 3'd4, C_WB,   4'hA);
        // ADD register, S=0: ALU flags must not load
        add(I_ADD,  4'h0, 1'b0, 3'd0, C_IRW,  4'hA);
        add(I_ADD,  4'h0, 1'b0, 3'd1, C_NONE, 4'hA);
        add(I_ADD,  4'hF, 1'b0, 3'd2, C_DPR,  4'hA);
        // BEQ fails again (Z cleared by CMP)
        add(I_BEQ,  4'h0, 1'b0, 3'd0, C_IRW,  4'hA);
        add(I_BEQ,  4'h0, 1'b0, 3'd1, C_PCW,  4'hA);
        // BLT passes with N=1, V=0
        add(I_BLT,  4'h0, 1'b0, 3'd0, C_IRW,  4'hA);
        add(I_BLT,  4'h0, 1'b0, 3'd1, C_NONE, 4'hA);
        add(I_BLT,  4'h0, 1'b0, 3'd2, C_BR,   4'hA);
`ifdef CTRL_MEM_HANDSHAKE_EN
        // STR with one wait cycle: MemWrite held, PCWr only with ack
        add(I_STR,  4'h0, 1'b0, 3'd0, C_IRW,  4'hA);
        add(I_STR,  4'h0, 1'b0, 3'd1, C_NONE, 4'hA);
        add(I_STR,  4'h0, 1'b0, 3'd2, C_LSE,  4'hA);
        add(I_STR,  4'h0, 1'b0, 3'd3, 11'h0A0, 4'hA);
        add(I_STR,  4'h0, 1'b1, 3'd3, C_STA,  4'hA);
`endif

        // reset state
        @(posedge clk); #1;
        chk("reset state", {29'd0, state}, 32'd0);
        chk("reset ctrl",  {21'd0, ctrl_v}, 32'd0);
        chk("reset flags", {28'd0, flags}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < nrows; i++) begin
            inst    = rows[i].inst;
            {alu_n, alu_z, alu_c, alu_v} = rows[i].aluf;
            mem_ack = rows[i].ack;
            @(negedge clk);
            chk($sformatf("row%0d state", i), {29'd0, state},  {29'd0, rows[i].st});
            chk($sformatf("row%0d ctrl", i),  {21'd0, ctrl_v}, {21'd0, rows[i].ctrl});
            chk($sformatf("row%0d flags", i), {28'd0, flags},  {28'd0, rows[i].fl});
            @(posedge clk); #1;
        end
        {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
        mem_ack = 1'b0;

        // LDR with mem_ack on the third MEM cycle; count cycles and MemRead cycles
        inst = I_LDR; ncyc = 0; nread = 0; mcnt = 0;
        for (int k = 0; k < 20; k++) begin
            mem_ack = (state == 3'd3) && (mcnt == 2);
            @(negedge clk);
            if (MemRead) nread++;
            if (state == 3'd3) mcnt++;
            ncyc++;
            @(posedge clk); #1;
            if (state == 3'd0) break;
        end
        mem_ack = 1'b0;
`ifdef CTRL_MEM_HANDSHAKE_EN
        chk("ldr wait cycles", ncyc, 32'd7);
        chk("ldr memread cycles", nread, 32'd3);
`else
        chk("ldr fixed cycles", ncyc, 32'd5);
        chk("ldr memread cycles", nread, 32'd1);
`endif

        // reset during MEM of an LDR aborts at once
        inst = I_LDR;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pre-abort state", {29'd0, state}, 32'd3);
        chk("pre-abort memread", {31'd0, MemRead}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort ctrl",  {21'd0, ctrl_v}, 32'd0);
        chk("abort state", {29'd0, state}, 32'd0);
        chk("abort flags", {28'd0, flags}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post-reset ctrl",  {21'd0, ctrl_v}, {21'd0, C_IRW});
        chk("post-reset state", {29'd0, state}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
